// File: rtl/one_wire_pkg.sv
// Shared 1-Wire definitions: opcodes, bus timing in microseconds and a
// helper that turns microseconds into clock cycles.
package one_wire_pkg;

  typedef logic [1:0] ow_op_t;

  localparam ow_op_t OW_OP_RESET = 2'd0;
  localparam ow_op_t OW_OP_WRITE = 2'd1;
  localparam ow_op_t OW_OP_READ  = 2'd2;
  localparam ow_op_t OW_OP_RSVD  = 2'd3;

  localparam int unsigned T_RSTL = 480;  // reset pulse low
  localparam int unsigned T_RSTH = 480;  // reset release / presence window
  localparam int unsigned T_PDS  = 70;   // presence sample point in release window
  localparam int unsigned T_LOW1 = 6;    // low time of a write-1 / read slot
  localparam int unsigned T_LOW0 = 60;   // low time of a write-0 slot
  localparam int unsigned T_SLOT = 70;   // full slot length
  localparam int unsigned T_RDS  = 15;   // read sample point from slot start

  function automatic int unsigned us_to_cycles(input int unsigned us,
                                               input int unsigned clk_mhz);
    return us * clk_mhz;
  endfunction

endpackage

// File: rtl/one_wire_sync2.sv
// Two-flop synchronizer for the raw bus level. Resets to 1 (idle bus).
module one_wire_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      q_r    <= 1'b1;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/one_wire_master_ctrl.sv
// 1-Wire bus master sequencer: turns byte-level commands into timed
// reset/presence and read/write slots on an open-drain wire.
module one_wire_master_ctrl #(
  parameter int CLK_MHZ = 100,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_presence,
  output logic       rsp_err,
  output logic       ow_drive_low,
  input  logic       ow_sense,
  output logic       busy
);

  import one_wire_pkg::*;

  if (CNT_W < $clog2(int'(T_RSTL) * CLK_MHZ + 1)) begin : g_cnt_w_too_small
    $error("one_wire_master_ctrl: CNT_W too small for the reset pulse length");
  end

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RST_LOW  = 3'd1;
  localparam logic [2:0] ST_RST_REL  = 3'd2;
  localparam logic [2:0] ST_SLOT_LOW = 3'd3;
  localparam logic [2:0] ST_SLOT_REL = 3'd4;
  localparam logic [2:0] ST_RESP     = 3'd5;

  localparam int unsigned MHZ = CLK_MHZ;
  localparam logic [CNT_W-1:0] C_RSTL_LAST = CNT_W'(us_to_cycles(T_RSTL, MHZ) - 1);
  localparam logic [CNT_W-1:0] C_RSTH_LAST = CNT_W'(us_to_cycles(T_RSTH, MHZ) - 1);
  localparam logic [CNT_W-1:0] C_PDS       = CNT_W'(us_to_cycles(T_PDS, MHZ));
  localparam logic [CNT_W-1:0] C_LOW1      = CNT_W'(us_to_cycles(T_LOW1, MHZ));
  localparam logic [CNT_W-1:0] C_LOW0      = CNT_W'(us_to_cycles(T_LOW0, MHZ));
  localparam logic [CNT_W-1:0] C_SLOT      = CNT_W'(us_to_cycles(T_SLOT, MHZ));
  // Read sample point counted from the start of the release phase.
  localparam logic [CNT_W-1:0] C_RDS_REL   = CNT_W'(us_to_cycles(T_RDS - T_LOW1, MHZ));

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  ow_op_t           op_r;
  logic [7:0]       tx_r;
  logic [7:0]       rx_r;
  logic [2:0]       bit_idx_r;
  logic             presence_r;
  logic             err_r;
  logic             ready_r;
  logic             busy_r;
  logic             drive_r;
  logic             rsp_valid_r;
  logic [7:0]       rsp_data_r;
  logic             rsp_presence_r;
  logic             rsp_err_r;

  logic             sense_s;
  logic             accept_s;
  logic             bit_val_s;
  logic [CNT_W-1:0] low_len_s;
  logic [CNT_W-1:0] low_last_s;
  logic [CNT_W-1:0] rel_last_s;

  one_wire_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ow_sense),
    .q     (sense_s)
  );

  assign accept_s = cmd_valid && ready_r && (state_r == ST_IDLE);

  // Slot shape: a write-0 holds the bus low long, everything else is short.
  always_comb begin
    bit_val_s = tx_r[bit_idx_r];
    if ((op_r == OW_OP_WRITE) && !bit_val_s) begin
      low_len_s = C_LOW0;
    end else begin
      low_len_s = C_LOW1;
    end
    low_last_s = low_len_s - CNT_W'(1);
    rel_last_s = C_SLOT - low_len_s - CNT_W'(1);
  end

  // Next-state decode of the sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OW_OP_RESET: state_nxt_s = ST_RST_LOW;
            OW_OP_WRITE: state_nxt_s = ST_SLOT_LOW;
            OW_OP_READ:  state_nxt_s = ST_SLOT_LOW;
            default:     state_nxt_s = ST_RESP;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RST_LOW: begin
        if (cnt_r == C_RSTL_LAST) begin
          state_nxt_s = ST_RST_REL;
        end else begin
          state_nxt_s = ST_RST_LOW;
        end
      end
      ST_RST_REL: begin
        if (cnt_r == C_RSTH_LAST) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_RST_REL;
        end
      end
      ST_SLOT_LOW: begin
        if (cnt_r == low_last_s) begin
          state_nxt_s = ST_SLOT_REL;
        end else begin
          state_nxt_s = ST_SLOT_LOW;
        end
      end
      ST_SLOT_REL: begin
        if (cnt_r != rel_last_s) begin
          state_nxt_s = ST_SLOT_REL;
        end else if (bit_idx_r == 3'd7) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_SLOT_LOW;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and slot counter, which restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Command latching, bit sequencing, bus sampling and error capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r       <= OW_OP_RESET;
      tx_r       <= 8'h00;
      rx_r       <= 8'h00;
      bit_idx_r  <= 3'd0;
      presence_r <= 1'b0;
      err_r      <= 1'b0;
    end else if (accept_s) begin
      op_r       <= cmd_op;
      tx_r       <= cmd_data;
      rx_r       <= 8'h00;
      bit_idx_r  <= 3'd0;
      presence_r <= 1'b0;
      err_r      <= (cmd_op == OW_OP_RSVD);
    end else begin
      if ((state_r == ST_RST_REL) && (cnt_r == C_PDS) && !sense_s) begin
        presence_r <= 1'b1;
      end
      if ((state_r == ST_RST_REL) && (cnt_r == C_RSTH_LAST) && !sense_s) begin
        err_r <= 1'b1;
      end
      if ((state_r == ST_SLOT_REL) && (op_r == OW_OP_READ) && (cnt_r == C_RDS_REL)) begin
        rx_r[bit_idx_r] <= sense_s;
      end
      if ((state_r == ST_SLOT_REL) && (cnt_r == rel_last_s)) begin
        if (!sense_s) begin
          err_r <= 1'b1;
        end
        if (bit_idx_r != 3'd7) begin
          bit_idx_r <= bit_idx_r + 3'd1;
        end
      end
    end
  end

  // Registered outputs; response fields are non-zero only on the rsp_valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r        <= 1'b1;
      busy_r         <= 1'b0;
      drive_r        <= 1'b0;
      rsp_valid_r    <= 1'b0;
      rsp_data_r     <= 8'h00;
      rsp_presence_r <= 1'b0;
      rsp_err_r      <= 1'b0;
    end else begin
      ready_r        <= (state_nxt_s == ST_IDLE) && (state_r != ST_RESP);
      busy_r         <= !((state_nxt_s == ST_IDLE) && (state_r != ST_RESP));
      drive_r        <= (state_nxt_s == ST_RST_LOW) || (state_nxt_s == ST_SLOT_LOW);
      rsp_valid_r    <= (state_r == ST_RESP);
      rsp_data_r     <= ((state_r == ST_RESP) && (op_r == OW_OP_READ)) ? rx_r : 8'h00;
      rsp_presence_r <= (state_r == ST_RESP) && (op_r == OW_OP_RESET) && presence_r;
      rsp_err_r      <= (state_r == ST_RESP) && err_r;
    end
  end

  assign cmd_ready    = ready_r;
  assign busy         = busy_r;
  assign ow_drive_low = drive_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;
  assign rsp_presence = rsp_presence_r;
  assign rsp_err      = rsp_err_r;

endmodule

// File: doc/one_wire_master_ctrl.md
Name: one_wire_master_ctrl

Overview:
- 1-Wire bus master sequencer. Accepts byte-level commands (bus reset/presence, write byte, read byte) over a valid/ready interface and generates the timed open-drain slots on the shared wire.
- Paired with the slave receiver on the same bus. Owns all master-side timing.
- Exposes separate drive/sense pins. The top level builds the tri-state: bus = ow_drive_low ? 0 : Z.

Parameters:
- CLK_MHZ, 100, clock frequency in MHz. All timing localparams are us * CLK_MHZ.
- CNT_W, 16, slot counter width. Must hold 480*CLK_MHZ; elaboration error if too small.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle, can accept
- cmd_op  in  2  0=RESET, 1=WRITE_BYTE, 2=READ_BYTE, 3=reserved
- cmd_data  in  8  byte to write (ignored otherwise)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  8  byte read (0 for other ops)
- rsp_presence  out  1  presence seen (RESET only)
- rsp_err  out  1  reserved opcode or bus stuck low
- ow_drive_low  out  1  pull bus low
- ow_sense  in  1  raw bus level, asynchronous
- busy  out  1  inverse of cmd_ready

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State IDLE, counters 0. ow_drive_low deasserts asynchronously on rst_n low, including mid-slot. No response is issued for an aborted command.
- ow_sense passes through a 2-flop synchronizer. All sampling uses the synchronized value, so there is 2 cycles of latency. Sample points below are counted on the slot counter and include no compensation.
- Handshake: command accepted when cmd_valid && cmd_ready. cmd_op and cmd_data are latched that cycle. cmd_ready drops the next cycle and rises on the cycle after rsp_valid.
- States: IDLE, RST_LOW, RST_REL, SLOT_LOW, SLOT_REL, RESP.
- The counter clears on every state change and otherwise increments.
- RESET:
  - RST_LOW: drive low for 480us.
  - RST_REL: release for 480us. presence_q is set if the synced bus is 0 at cnt == 70us.
  - If the bus is still 0 at the end of RST_REL: rsp_err=1.
- WRITE_BYTE: 8 slots, LSB first.
  - Bit 1: drive low 6us, then release 64us.
  - Bit 0: drive low 60us, then release 10us.
- READ_BYTE: 8 slots, LSB first. Drive low 6us, then release 64us. Sample the synced bus at SLOT_REL cnt == 9us (15us from slot start). Shift into rx_sr[bit_idx].
- Slot sequencing:
  - Each slot is exactly 70us. The next slot starts with SLOT_LOW the cycle after SLOT_REL ends.
  - bit_idx is 3 bits, 0..7. The terminal check is bit_idx==7, so there is no wrap.
- Bus-stuck check: if the synced bus is 0 on the last cycle of any SLOT_REL, set err_q. The byte still completes.
- Reserved op: go directly to RESP with rsp_err=1. No bus activity.
- RESP: one cycle with rsp_valid=1. rsp_data, rsp_presence and rsp_err are valid that cycle only and are 0 otherwise. Return to IDLE.
- A command presented during the RESP cycle is not accepted (cmd_ready=0). It is accepted the next cycle.
- Latency, accept to rsp_valid:
  - RESET: 960us*CLK_MHZ + 2 cycles.
  - Byte: 8*70us*CLK_MHZ + 2 cycles.
  - Reserved: 2 cycles.

Decomposition:
- Package one_wire_pkg:
  - opcode constants OW_OP_RESET/WRITE/READ/RSVD
  - timing constants in us: T_RSTL=480, T_RSTH=480, T_PDS=70, T_LOW1=6, T_LOW0=60, T_SLOT=70, T_RDS=15
  - shared with one_wire_rx
- Sub-module one_wire_sync2 (2-flop synchronizer, reset value 1).

Test Plan (CLK_MHZ=1):
- RESET, bench model pulls bus low from 30 to 150 cycles after release -> ow_drive_low high 480 cycles; rsp_valid 962 cycles after accept; rsp_presence=1, rsp_err=0.
- RESET, no device -> rsp_presence=0, rsp_err=0, same latency.
- WRITE_BYTE 0xA5 -> low pulses 6,60,6,60,60,6,60,6 cycles, each slot 70 cycles apart; rsp_valid at 562, rsp_data=0.
- READ_BYTE, model holds bus low 40 cycles in slots for bits 1,3,6 (value 0xB5) -> rsp_data=0xB5, rsp_err=0.
- Bus held low throughout WRITE_BYTE 0xFF -> completes, rsp_err=1. Then cmd_op=3 -> rsp_valid 2 cycles later, rsp_err=1, ow_drive_low never asserted.
- rst_n pulsed low at cycle 20 of RST_LOW -> ow_drive_low=0 in the same cycle, no rsp_valid, cmd_ready=1 after release.
